// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        DRAIN,
        DONE
    } seq_state_t;

    // Step counter width: one bit wider than k_len, and never narrower than
    // what the longest window k_max + 2n - 2 needs.
    function automatic int t_width(input int k_max, input int n);
        int w;
        int need;
        w    = $clog2(k_max + 1) + 1;
        need = $clog2(k_max + 2 * n - 2 + 1);
        if (need > w) begin
            w = need;
        end
        return w;
    endfunction

endpackage

// File: rtl/systolic_sequencer_skew.sv
// Turns one enable pulse into N copies, copy i delayed by i cycles, for the
// diagonal operand wavefront at the array edge.
module skew_enable_gen #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_in,
    output logic [N-1:0] en_out
);

    generate
        if (N > 1) begin : g_shift
            logic [N-2:0] stage_q;
            logic [N-2:0] stage_d;

            always_comb begin
                stage_d[0] = en_in;
                for (int i = 1; i < N - 1; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign en_out = {stage_q, en_in};
        end else begin : g_single
            assign en_out = en_in;
        end
    endgenerate

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for an NxN output-stationary systolic array: clear, skewed
// operand feed for k_len + 2N - 2 steps, then row-by-row result drain.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 255,
    parameter int K_W   = $clog2(K_MAX + 1),
    parameter int S_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    output logic           busy,
    output logic           done,
    output logic           acc_rst,
    output logic           acc_en,
    output logic           shift_en,
    output logic [N-1:0]   row_rd_en,
    output logic [N-1:0]   col_rd_en,
    output logic           feed_zero,
    output logic [S_W-1:0] row_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int T_W = t_width(K_MAX, N);
    localparam logic [T_W-1:0] SKEW = T_W'(2 * N - 2);
    localparam logic [S_W-1:0] LAST_ROW = S_W'(N - 1);

    seq_state_t     state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [T_W-1:0] t_q, t_d;
    logic [S_W-1:0] row_sel_q, row_sel_d;
    logic [T_W-1:0] w_len;
    logic           feed_pulse;

    assign w_len      = T_W'(k_q) + SKEW;
    // Single k_len-long pulse; the skew generators delay it per row/column.
    assign feed_pulse = (state_q == COMPUTE) && (t_q < T_W'(k_q));

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        row_sel_d = row_sel_q;
        busy      = 1'b1;
        done      = 1'b0;
        acc_rst   = 1'b0;
        acc_en    = 1'b0;
        shift_en  = 1'b0;
        feed_zero = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                t_d       = '0;
                row_sel_d = '0;
                if (start) begin
                    k_d     = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_rst   = 1'b1;
                shift_en  = 1'b1;
                feed_zero = 1'b1;
                t_d       = '0;
                state_d   = (k_q == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                acc_en   = 1'b1;
                shift_en = 1'b1;
                if (t_q == w_len - T_W'(1)) begin
                    t_d     = '0;
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_sel_q == LAST_ROW) begin
                        row_sel_d = '0;
                        state_d   = DONE;
                    end else begin
                        row_sel_d = row_sel_q + S_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            t_q       <= '0;
            row_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            t_q       <= t_d;
            row_sel_q <= row_sel_d;
        end
    end

    assign row_sel = row_sel_q;

    skew_enable_gen #(.N(N)) u_row_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_in  (feed_pulse),
        .en_out (row_rd_en)
    );

    skew_enable_gen #(.N(N)) u_col_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_in  (feed_pulse),
        .en_out (col_rd_en)
    );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: drives commands, models the MAC array and its
// edge buffers from the sequencer's controls, and scoreboards the drained rows.
module tb_systolic_sequencer;

    localparam int N     = 4;
    localparam int K_MAX = 255;
    localparam int K_W   = 8;
    localparam int MEM_D = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           out_ready = 1'b1;
    logic [K_W-1:0] k_len = '0;
    logic           busy, done, acc_rst, acc_en, shift_en, feed_zero, out_valid;
    logic [N-1:0]   row_rd_en, col_rd_en;
    logic [1:0]     row_sel;

    systolic_sequencer #(.N(N), .K_MAX(K_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .acc_rst   (acc_rst),
        .acc_en    (acc_en),
        .shift_en  (shift_en),
        .row_rd_en (row_rd_en),
        .col_rd_en (col_rd_en),
        .feed_zero (feed_zero),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int start_cyc;
        int k;
        int exp_done;
    } cmd_t;

    typedef struct packed {
        logic [1:0]       idx;
        logic [4*32-1:0]  data;
    } row_exp_t;

    cmd_t     cmd_q[$];
    row_exp_t row_q[$];
    int       a_mem [N][MEM_D];
    int       b_mem [MEM_D][N];
    logic     stim_done = 1'b0;

    // ---------------- monitor / scoreboard / array model ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int acc [N][N];
    int a_pipe [N][N];
    int b_pipe [N][N];
    int a_in [N][N];
    int b_in [N][N];
    int left_v [N];
    int top_v [N];
    int a_ptr [N];
    int b_ptr [N];
    int rd_cnt [2*N];
    int r3_first, r3_last, comp_cnt, rst_cnt, accept_cnt;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [1:0] prev_sel = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmd_t     c;
        row_exp_t e;
        int       ev;
        if (!rst_n) begin
            check("reset_outputs", {busy, done, acc_rst, acc_en, shift_en, feed_zero,
                                    out_valid, row_rd_en, col_rd_en, row_sel}, 0);
            cmd_q.delete();
            row_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (cmd_q.size() > 0 && cyc == cmd_q[0].start_cyc) begin
                for (int i = 0; i < 2*N; i++) rd_cnt[i] = 0;
                r3_first = -1; r3_last = -1;
                comp_cnt = 0; rst_cnt = 0; accept_cnt = 0;
            end

            if (cmd_q.size() == 0 || cyc <= cmd_q[0].start_cyc) begin
                check("busy_idle", busy, 0);
                check("idle_quiet", {done, acc_rst, acc_en, shift_en, feed_zero,
                                     out_valid, row_rd_en, col_rd_en}, 0);
            end else begin
                check("busy_active", busy, 1);
                for (int i = 0; i < N; i++) begin
                    rd_cnt[i]   += int'(row_rd_en[i]);
                    rd_cnt[N+i] += int'(col_rd_en[i]);
                end
                if (row_rd_en[N-1]) begin
                    if (r3_first < 0) r3_first = cyc;
                    r3_last = cyc;
                end
                if (acc_en && shift_en) comp_cnt++;
                if (acc_rst) begin
                    rst_cnt++;
                    check("acc_rst_cycle", cyc, cmd_q[0].start_cyc + 1);
                    check("clear_ctrl", {shift_en, feed_zero, acc_en}, 3'b110);
                end
            end

            if (prev_valid && !prev_ready) begin
                check("valid_held", out_valid, 1);
                check("row_sel_stable", row_sel, prev_sel);
            end

            if (out_valid && out_ready) begin
                if (row_q.size() > 0) begin
                    e = row_q.pop_front();
                    accept_cnt++;
                    check("row_sel_order", row_sel, e.idx);
                    for (int j = 0; j < N; j++) begin
                        ev = e.data[j*32 +: 32];
                        check("row_data", acc[row_sel][j], ev);
                    end
                end else begin
                    check("row_unexpected", 1, 0);
                end
            end

            if (done) begin
                if (cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    if (c.exp_done >= 0) check("done_cycle", cyc, c.exp_done);
                    check("clear_count", rst_cnt, 1);
                    check("compute_len", comp_cnt, (c.k == 0) ? 0 : c.k + 2*N - 2);
                    check("accept_count", accept_cnt, N);
                    for (int i = 0; i < 2*N; i++) check("rd_en_count", rd_cnt[i], c.k);
                    check("row3_first", r3_first, (c.k > 0) ? c.start_cyc + 2 + N - 1 : -1);
                    check("row3_last", r3_last, (c.k > 0) ? c.start_cyc + N + c.k : -1);
                end else begin
                    check("done_unexpected", 1, 0);
                end
            end

            if (cmd_q.size() > 0 && cyc > cmd_q[0].start_cyc + 300) begin
                check("cmd_timeout", 0, 1);
                void'(cmd_q.pop_front());
                row_q.delete();
            end

            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_sel   = row_sel;
        end

        // Array model: what the MAC cells do on the coming clock edge.
        if (rst_n && acc_rst) begin
            for (int i = 0; i < N; i++) begin
                a_ptr[i] = 0; b_ptr[i] = 0;
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = 0; a_pipe[i][j] = 0; b_pipe[i][j] = 0;
                end
            end
        end else if (rst_n && shift_en) begin
            for (int i = 0; i < N; i++) begin
                left_v[i] = 0;
                top_v[i]  = 0;
                if (row_rd_en[i] && !feed_zero) begin
                    if (a_ptr[i] < MEM_D) left_v[i] = a_mem[i][a_ptr[i]];
                    a_ptr[i]++;
                end
                if (col_rd_en[i] && !feed_zero) begin
                    if (b_ptr[i] < MEM_D) top_v[i] = b_mem[b_ptr[i]][i];
                    b_ptr[i]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_in[i][j] = (j == 0) ? left_v[i] : a_pipe[i][j-1];
                    b_in[i][j] = (i == 0) ? top_v[j]  : b_pipe[i-1][j];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (acc_en) acc[i][j] += a_in[i][j] * b_in[i][j];
                    a_pipe[i][j] = a_in[i][j];
                    b_pipe[i][j] = b_in[i][j];
                end
            end
        end

        if (cyc > 20000) begin
            check("global_timeout", 0, 1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
        if (stim_done) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && cmd_q.size() != 0; i++) step();
    endtask

    task automatic issue(input int k, input int exp_lat);
        cmd_t     c;
        row_exp_t r;
        int       s;
        for (int i = 0; i < N; i++) begin
            r.idx  = 2'(i);
            r.data = '0;
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int p = 0; p < k; p++) s += a_mem[i][p] * b_mem[p][j];
                r.data[j*32 +: 32] = s;
            end
            row_q.push_back(r);
        end
        c.start_cyc = cyc;
        c.k         = k;
        c.exp_done  = (exp_lat < 0) ? -1 : cyc + exp_lat;
        cmd_q.push_back(c);
        start = 1'b1;
        k_len = K_W'(k);
        step();
        start = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        start = 1'b1;
        k_len = K_W'(k);
        step();
        start = 1'b0;
    endtask

    task automatic load(input int sel);
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < MEM_D; p++) begin
                case (sel)
                    0: begin a_mem[i][p] = i*5 - p*3 - 2;      b_mem[p][i] = p*4 - i*6 + 1; end
                    1: begin a_mem[i][p] = (i == 0 && p == 0) ? -128 : i*7 - p*11 + 3;
                             b_mem[p][i] = 127; end
                    default: begin a_mem[i][p] = 9 - i*p;      b_mem[p][i] = (p + i) * 3 - 7; end
                endcase
            end
        end
    endtask

    logic [15:0] ready_pat = 16'b1001_0110_1100_1001;
    int s0;

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // k_len=3 baseline timing and products
        load(0);
        issue(3, 15);
        wait_idle();

        // int8 corners: A contains -128, B all 127
        load(1);
        issue(4, 16);
        wait_idle();

        // Back-pressure on the drain port
        load(2);
        issue(2, -1);
        for (int c = 0; c < 60 && cmd_q.size() > 0; c++) begin
            out_ready = ready_pat[c % 16];
            step();
        end
        out_ready = 1'b1;
        wait_idle();

        // Zero-length reduction: zero rows, done at start+6
        load(0);
        issue(0, 6);
        wait_idle();

        // Starts during COMPUTE, DRAIN and DONE are ignored; IDLE start accepted
        load(2);
        s0 = cyc;
        issue(3, 15);
        wait_until(s0 + 6);
        pulse_start(7);
        wait_until(s0 + 12);
        pulse_start(5);
        wait_until(s0 + 15);
        pulse_start(6);
        load(0);
        issue(1, 13);
        wait_idle();

        // Asynchronous reset at COMPUTE t=4, then a fresh k_len=2 command
        load(1);
        s0 = cyc;
        issue(5, -1);
        wait_until(s0 + 6);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        load(2);
        issue(2, 14);
        wait_idle();

        repeat (3) step();
        stim_done = 1'b1;
    end

endmodule
